fredkin_gate_arbiter: RTL and testbench



---
 rtl/fredkin_gate_arbiter.sv | 139 +++++++++++++
 tb/tb_fredkin_gate_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fredkin_gate_arbiter.sv
// Round-robin sequencer sharing one Fredkin gate among requesters.
// Each op runs a forward pass, then an inverse pass to check reversibility.
module fredkin_gate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_c,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] gnt,
  output logic               fg_c,
  output logic               fg_a,
  output logic               fg_b,
  input  logic               fg_p,
  input  logic               fg_q,
  input  logic               fg_r,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_p,
  output logic               rsp_q,
  output logic               rsp_r,
  output logic               rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    INV,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            op_c, op_a, op_b;
  logic            res_p, res_q, res_r;

  // Search upward from the slot after the last winner, wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    idx     = 0;
    cand    = '0;
    win_vld = 1'b0;
    win_id  = last_id;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_id) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fg_c      = 1'b0;
    fg_a      = 1'b0;
    fg_b      = 1'b0;
    gnt       = '0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) state_nxt = FWD;
      end
      FWD: begin
        fg_c      = op_c;
        fg_a      = op_a;
        fg_b      = op_b;
        gnt       = NUM_REQ'(1) << cur_id;
        state_nxt = INV;
      end
      INV: begin
        fg_c      = res_p;
        fg_a      = res_q;
        fg_b      = res_r;
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= ID_W'(NUM_REQ - 1);
      cur_id  <= '0;
      op_c    <= 1'b0;
      op_a    <= 1'b0;
      op_b    <= 1'b0;
      res_p   <= 1'b0;
      res_q   <= 1'b0;
      res_r   <= 1'b0;
      rsp_id  <= '0;
      rsp_p   <= 1'b0;
      rsp_q   <= 1'b0;
      rsp_r   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && win_vld) begin
        op_c    <= req_c[win_id];
        op_a    <= req_a[win_id];
        op_b    <= req_b[win_id];
        cur_id  <= win_id;
        last_id <= win_id;
      end
      if (state == FWD) begin
        res_p <= fg_p;
        res_q <= fg_q;
        res_r <= fg_r;
      end
      // Response regs load entering DONE and hold afterwards.
      if (state == INV) begin
        rsp_id  <= cur_id;
        rsp_p   <= res_p;
        rsp_q   <= res_q;
        rsp_r   <= res_r;
        rsp_err <= {fg_p, fg_q, fg_r} != {op_c, op_a, op_b};
      end
    end
  end

endmodule

// File: tb/tb_fredkin_gate_arbiter.sv
// Bench for fredkin_gate_arbiter: gate model, grant and response
// scoreboards, and directed sequences.
module tb_fredkin_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_c, req_a, req_b;
  logic [3:0] gnt;
  logic       fg_c, fg_a, fg_b, fg_p, fg_q, fg_r;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_p, rsp_q, rsp_r, rsp_err;
  logic       stuck;

  int errors = 0;
  int checks = 0;
  int gcnt = 0;
  int vcnt = 0;

  typedef struct {
    int id;
    bit c, a, b, p, q, r, err;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t cur;
  bit   inv_chk = 1'b0;
  bit   prev_v = 1'b0;

  always #5 clk = ~clk;

  assign fg_p = fg_c;
  assign fg_q = stuck ? 1'b0 : (fg_c ? fg_b : fg_a);
  assign fg_r = fg_c ? fg_a : fg_b;

  fredkin_gate_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_c(req_c), .req_a(req_a), .req_b(req_b),
    .gnt(gnt),
    .fg_c(fg_c), .fg_a(fg_a), .fg_b(fg_b),
    .fg_p(fg_p), .fg_q(fg_q), .fg_r(fg_r),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_p(rsp_p), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    bit   ip, iq, ir;
    e.id  = id;
    e.c   = req_c[id];
    e.a   = req_a[id];
    e.b   = req_b[id];
    e.p   = e.c;
    e.q   = stuck ? 1'b0 : (e.c ? e.b : e.a);
    e.r   = e.c ? e.a : e.b;
    ip    = e.p;
    iq    = stuck ? 1'b0 : (e.p ? e.r : e.q);
    ir    = e.p ? e.q : e.r;
    e.err = {ip, iq, ir} != {e.c, e.a, e.b};
    gq.push_back(e);
    rq.push_back(e);
  endtask

  task automatic serve(input logic [3:0] m);
    req = req | m;
    for (int i = 0; i < 200 && rq.size() > 0; i++) begin
      @(negedge clk);
      req = req & ~gnt;
    end
    chk("drain", rq.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (inv_chk) begin
      chk("fg_inv", {fg_c, fg_a, fg_b}, {cur.p, cur.q, cur.r});
      inv_chk = 1'b0;
    end
    if (gnt != 4'b0) begin
      gcnt++;
      if (gq.size() == 0) begin
        chk("gnt_unexp", gnt, 0);
      end else begin
        e = gq.pop_front();
        chk("gnt", gnt, 4'b1 << e.id);
        chk("fg_fwd", {fg_c, fg_a, fg_b}, {e.c, e.a, e.b});
        cur = e;
        inv_chk = 1'b1;
      end
    end
    if (rsp_valid) begin
      vcnt++;
      chk("valid_b2b", prev_v, 0);
      if (rq.size() == 0) begin
        chk("rsp_unexp", rsp_valid, 0);
      end else begin
        e = rq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_pqr", {rsp_p, rsp_q, rsp_r}, {e.p, e.q, e.r});
        chk("rsp_err", rsp_err, e.err);
      end
    end
    prev_v = rsp_valid;
  end

  initial begin
    int n, last, g0, v0;
    rst = 1'b1; req = '0; req_c = '0; req_a = '0; req_b = '0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_id, rsp_p, rsp_q, rsp_r, rsp_err}, 0);
    chk("rst_fg", {fg_c, fg_a, fg_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // swap case with explicit latency
    req_c = 4'b0100; req_a = 4'b0000; req_b = 4'b0100;
    push(2);
    req = 4'b0100;
    @(negedge clk);
    chk("swap_gnt", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("swap_lat", rsp_valid, 1);
    @(negedge clk);

    // pass-through
    req_c = 4'b0000; req_a = 4'b0001; req_b = 4'b0000;
    push(0);
    serve(4'b0001);

    // fairness after serving 1
    req_c = 4'b1010; req_a = 4'b0011; req_b = 4'b1001;
    push(1);
    serve(4'b0010);
    push(3); push(0); push(1);
    serve(4'b1011);

    // stuck-at-0 on q, then healthy gate
    req_c = 4'b0000; req_a = 4'b0010; req_b = 4'b0010;
    stuck = 1'b1;
    push(1);
    serve(4'b0010);
    stuck = 1'b0;
    push(1);
    serve(4'b0010);

    // continuous requests from all four
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g0 = gcnt; v0 = vcnt;
    req_c = 4'b0110; req_a = 4'b1100; req_b = 4'b1010;
    push(0); push(1); push(2); push(3); push(0);
    req = 4'b1111;
    n = 0; last = 0;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        if (n > 0) chk("spacing", cyc - last, 4);
        last = cyc;
        n++;
        if (n == 5) req = '0;
      end
    end
    chk("n_grants", n, 5);
    serve(4'b0000);
    chk("valid_eq_gnt", vcnt - v0, gcnt - g0);

    // reset during INV
    req_c = 4'b0100; req_a = 4'b0100; req_b = 4'b0000;
    push(2);
    req = 4'b0100;
    @(negedge clk);
    chk("ri_gnt", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ri_gnt0", gnt, 0);
    chk("ri_valid0", rsp_valid, 0);
    chk("ri_fg0", {fg_c, fg_a, fg_b}, 0);
    chk("ri_rsp0", {rsp_id, rsp_p, rsp_q, rsp_r, rsp_err}, 0);
    rq.delete();
    gq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    req_c = 4'b1000; req_a = 4'b0001; req_b = 4'b1001;
    push(0); push(3);
    serve(4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
